// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// -------------
// Wraps a single-port, registered-output data memory as a byte FIFO.
// Bytes accepted on the valid/ready input stream are written to consecutive
// RAM locations. They are read back in order and prefetched into a
// registered output stage. That stage gives one extra byte of storage, so the
// FIFO holds DEPTH+1 bytes in total.
//
// Parameters:
//   DEPTH   RAM entries used (power of two, 2 <= DEPTH <= 2**ADDR_W)
//   ADDR_W  width of the RAM address port
//   DATA_W  data width
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush; empties the FIFO and discards any read in flight
//   in_valid   upstream byte valid
//   in_data    upstream byte
//   in_ready   byte is accepted this cycle (low while a read uses the port)
//   out_valid  out_data holds the oldest unread byte
//   out_data   registered output byte
//   out_ready  downstream consumes out_data
//   ram_we     memory write enable
//   ram_re     memory read enable
//   ram_addr   memory address (pointer zero-extended to ADDR_W)
//   ram_wdata  memory write data
//   ram_rdata  memory read data, valid the cycle after ram_re
//   count      bytes held in RAM (excludes output register and in-flight read)
//   full       count == DEPTH
//   empty      nothing held anywhere: RAM, in-flight read or output register
module ram_fifo_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic                       ram_we,
  output logic                       ram_re,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  input  logic [DATA_W-1:0]          ram_rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              rdPending_q, rdPending_d;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;

  logic rdGo;
  logic wrGo;
  logic inReady;

  // Reads win the single port. A read is only issued when the output
  // register is free by the time its data returns (empty now, or being
  // consumed this cycle), and never while the previous read is in flight.
  always_comb begin
    rdGo    = !clear && !rdPending_q && (count_q != '0) && (!outValid_q || out_ready);
    inReady = !clear && (count_q != FullCount) && !rdGo;
    wrGo    = in_valid && inReady;
  end

  // The address carries the read pointer when a read is issued and the
  // write pointer otherwise; upper address bits stay zero.
  always_comb begin
    ram_addr = '0;
    if (rdGo) begin
      ram_addr[PtrW-1:0] = rdPtr_q;
    end else begin
      ram_addr[PtrW-1:0] = wrPtr_q;
    end
  end

  // Next-state logic. rdGo and wrGo are mutually exclusive, so count never
  // moves in both directions at once. Read data is captured exactly one
  // cycle after its request; rdPending marks that cycle.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    rdPending_d = rdPending_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;

    if (clear) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      rdPending_d = 1'b0;
      outValid_d  = 1'b0;
    end else begin
      if (rdPending_q) begin
        outData_d   = ram_rdata;
        outValid_d  = 1'b1;
        rdPending_d = 1'b0;
      end else if (outValid_q && out_ready) begin
        outValid_d = 1'b0;
      end

      if (rdGo) begin
        rdPtr_d     = rdPtr_q + 1'b1;
        count_d     = count_q - 1'b1;
        rdPending_d = 1'b1;
      end

      if (wrGo) begin
        wrPtr_d = wrPtr_q + 1'b1;
        count_d = count_q + 1'b1;
      end
    end
  end

  // State register; reset drops any read in flight along with the contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      rdPending_q <= 1'b0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      rdPending_q <= rdPending_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
    end
  end

  assign in_ready  = inReady;
  assign ram_re    = rdGo;
  assign ram_we    = wrGo;
  assign ram_wdata = in_data;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign count     = count_q;
  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0) && !rdPending_q && !outValid_q;

endmodule
